// File: rtl/axi_chk_pkg.sv
// Shared definitions for the AXI4 read-channel protocol checker.
//   - register offsets of the cfg_chk_* register port
//   - bit positions inside the status register
//   - the outstanding-AR tracking entry {id, len, addr}
// The entry uses the largest supported field widths. Narrower bus fields
// are zero-extended on push, so one entry type serves every parameter set.
package axi_chk_pkg;

    localparam int MAX_ID_W   = 32;
    localparam int MAX_LEN_W  = 8;
    localparam int MAX_ADDR_W = 64;

    localparam logic [11:0] REG_STATUS      = 12'h000;
    localparam logic [11:0] REG_ERR_ADDR_LO = 12'h004;
    localparam logic [11:0] REG_ERR_ADDR_HI = 12'h008;
    localparam logic [11:0] REG_ERR_ID      = 12'h00C;
    localparam logic [11:0] REG_OUTSTANDING = 12'h010;
    localparam logic [11:0] REG_SLVERR_CNT  = 12'h014;

    localparam int ST_LAST_EARLY      = 0;
    localparam int ST_LAST_INCOMPLETE = 1;
    localparam int ST_ID_MISMATCH     = 2;
    localparam int ST_UNEXP           = 3;
    localparam int ST_AR_OVF          = 4;
    localparam int NUM_ST             = 5;

    typedef struct packed {
        logic [MAX_ID_W-1:0]   id;
        logic [MAX_LEN_W-1:0]  len;
        logic [MAX_ADDR_W-1:0] addr;
    } ar_entry_t;

endpackage

// File: rtl/axi_rd_prot_chk_if.sv
// AXI4 read address (AR) and read data (R) channel bundle.
//   master : drives AR payload/valid and rready
//   slave  : drives arready and R payload/valid
//   mon    : every signal as input, for passive observers such as the checker
interface axi_rd_prot_chk_if #(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 512
) ();
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [LEN_WIDTH-1:0]  arlen;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport mon (
        input arid, araddr, arlen, arsize, arvalid, arready,
        input rid, rdata, rresp, rlast, rvalid, rready
    );

endinterface

// File: rtl/axi_chk_ar_fifo.sv
// In-order tracking FIFO for accepted AR bursts.
//   clk, rst_n   clock, async active-low reset (pointers and count only)
//   push_i       write push_data_i when there is room (or a pop frees a slot)
//   pop_i        retire the head entry; ignored while empty
//   head_o       oldest entry, taken from storage; a pushed entry is visible
//                here the cycle after the push
//   valid_o      head_o holds a live entry
//   full_o       all DEPTH slots occupied
//   count_o      occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module axi_chk_ar_fifo
    import axi_chk_pkg::*;
#(
    parameter int  DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  ar_entry_t   push_data_i,
    input  logic        pop_i,
    output ar_entry_t   head_o,
    output logic        valid_o,
    output logic        full_o,
    output logic [AW:0] count_o
);

    ar_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & valid_o;
    // A pop in the same cycle frees the slot, so a push at full is accepted then.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is deliberately not reset; only pointers/count are, and they gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/axi_rd_prot_chk.sv
// Passive AXI4 read-channel protocol monitor. Observes AR/R, drives nothing
// on the bus. Accepted AR bursts are tracked in order; each R handshake is
// checked for an outstanding burst, a matching RID and RLAST on beat ARLEN.
// The first check failure is sticky and captures the burst address/ID.
//   clk, rst_n         clock, async active-low reset
//   cfg_chk_addr       register address (12 bit)
//   cfg_chk_wr/rd      register write/read strobes, acted on at their rising edge
//   cfg_chk_wdata      register write data
//   chk_cfg_ack        one-cycle pulse the cycle after a wr/rd rising edge
//   chk_cfg_rdata      read data, valid with ack (0 otherwise)
//   rd_error           registered OR of the status bits
//   bus                AR/R channel, observe-only modport
// Register map: 0x00 status (W1C), 0x04/0x08 err_addr lo/hi, 0x0C err_id,
// 0x10 outstanding bursts, 0x14 SLVERR beat count (any write clears).
// LEN_WIDTH must not exceed 8, ID_WIDTH 32 or ADDR_WIDTH 64.
module axi_rd_prot_chk
    import axi_chk_pkg::*;
#(
    parameter int ID_WIDTH   = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [11:0]        cfg_chk_addr,
    input  logic               cfg_chk_wr,
    input  logic               cfg_chk_rd,
    input  logic [31:0]        cfg_chk_wdata,
    output logic               chk_cfg_ack,
    output logic [31:0]        chk_cfg_rdata,
    output logic               rd_error,
    axi_rd_prot_chk_if.mon     bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ar_entry_t             push_entry, head;
    logic                  head_valid, fifo_full, pop;
    logic [CW-1:0]         fifo_count;
    logic                  ar_hs, r_hs, last_beat;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [NUM_ST-1:0]     set_mask, w1c_mask, status_q, status_d;
    logic [MAX_ADDR_W-1:0] cap_addr, err_addr_q, err_addr_d;
    logic [MAX_ID_W-1:0]   cap_id, err_id_q, err_id_d;
    logic [15:0]           slverr_q, slverr_d;
    logic                  wr_q, rd_q, wr_rise, rd_rise;
    logic                  ack_q;
    logic [31:0]           rdata_q, rdata_d, reg_val;
    logic                  rd_error_q;

    // Payload observed but not checked.
    logic [DATA_WIDTH-1:0] unused_rdata;
    logic                  unused_bits;
    assign unused_rdata = bus.rdata;
    assign unused_bits  = ^{bus.arsize, bus.rresp[0]};

    assign ar_hs = bus.arvalid & bus.arready;
    assign r_hs  = bus.rvalid & bus.rready;

    assign push_entry.id   = MAX_ID_W'(bus.arid);
    assign push_entry.len  = MAX_LEN_W'(bus.arlen);
    assign push_entry.addr = MAX_ADDR_W'(bus.araddr);

    axi_chk_ar_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_ar_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ar_hs),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (head_valid),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign wr_rise = cfg_chk_wr & ~wr_q;
    assign rd_rise = cfg_chk_rd & ~rd_q;

    // Beat checks: only an R handshake advances anything. At most one check
    // bit is raised per beat, in priority UNEXP > ID > EARLY > INCOMPLETE.
    always_comb begin
        set_mask  = '0;
        pop       = 1'b0;
        beat_d    = beat_q;
        cap_addr  = '0;
        cap_id    = '0;
        last_beat = (MAX_LEN_W'(beat_q) == head.len);
        if (r_hs) begin
            if (!head_valid) begin
                set_mask[ST_UNEXP] = 1'b1;
            end else begin
                cap_addr = head.addr;
                cap_id   = head.id;
                if (MAX_ID_W'(bus.rid) != head.id)  set_mask[ST_ID_MISMATCH]     = 1'b1;
                else if (bus.rlast && !last_beat)   set_mask[ST_LAST_EARLY]      = 1'b1;
                else if (!bus.rlast && last_beat)   set_mask[ST_LAST_INCOMPLETE] = 1'b1;
                // The burst ends on RLAST or on beat ARLEN, whichever comes
                // first, so the counter never runs past ARLEN and never wraps.
                if (bus.rlast || last_beat) begin
                    pop    = 1'b1;
                    beat_d = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end
        // First-error-only for the four beat checks; AR_OVF neither gates
        // nor is gated.
        if (status_q[ST_UNEXP:0] != '0) set_mask[ST_UNEXP:0] = '0;
        set_mask[ST_AR_OVF] = ar_hs & fifo_full & ~pop;
    end

    // Status, capture and SLVERR counter. A set beats a W1C on the same bit.
    always_comb begin
        w1c_mask   = (wr_rise && cfg_chk_addr == REG_STATUS) ? cfg_chk_wdata[NUM_ST-1:0] : '0;
        status_d   = (status_q & ~w1c_mask) | set_mask;
        err_addr_d = err_addr_q;
        err_id_d   = err_id_q;
        if (set_mask[ST_UNEXP:0] != '0) begin
            err_addr_d = cap_addr;
            err_id_d   = cap_id;
        end
        slverr_d = slverr_q;
        if (wr_rise && cfg_chk_addr == REG_SLVERR_CNT) slverr_d = '0;
        else if (r_hs && bus.rresp[1] && slverr_q != 16'hFFFF) slverr_d = slverr_q + 1'b1;
    end

    always_comb begin
        case (cfg_chk_addr)
            REG_STATUS:      reg_val = 32'(status_q);
            REG_ERR_ADDR_LO: reg_val = err_addr_q[31:0];
            REG_ERR_ADDR_HI: reg_val = err_addr_q[63:32];
            REG_ERR_ID:      reg_val = err_id_q;
            REG_OUTSTANDING: reg_val = 32'(fifo_count);
            REG_SLVERR_CNT:  reg_val = 32'(slverr_q);
            default:         reg_val = '0;
        endcase
        rdata_d = rd_rise ? reg_val : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q     <= '0;
            status_q   <= '0;
            err_addr_q <= '0;
            err_id_q   <= '0;
            slverr_q   <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            rd_error_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            status_q   <= status_d;
            err_addr_q <= err_addr_d;
            err_id_q   <= err_id_d;
            slverr_q   <= slverr_d;
            wr_q       <= cfg_chk_wr;
            rd_q       <= cfg_chk_rd;
            ack_q      <= wr_rise | rd_rise;
            rdata_q    <= rdata_d;
            rd_error_q <= |status_q;
        end
    end

    assign chk_cfg_ack   = ack_q;
    assign chk_cfg_rdata = rdata_q;
    assign rd_error      = rd_error_q;

endmodule

// File: tb/tb_axi_rd_prot_chk.sv
// Directed self-checking bench for axi_rd_prot_chk.
module tb_axi_rd_prot_chk;
    import axi_chk_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cfg_chk_addr = '0;
    logic        cfg_chk_wr = 1'b0;
    logic        cfg_chk_rd = 1'b0;
    logic [31:0] cfg_chk_wdata = '0;
    logic        chk_cfg_ack;
    logic [31:0] chk_cfg_rdata;
    logic        rd_error;

    int checks   = 0;
    int failures = 0;

    axi_rd_prot_chk_if #(
        .ID_WIDTH(16), .ADDR_WIDTH(64), .LEN_WIDTH(8), .DATA_WIDTH(512)
    ) bus_if ();

    axi_rd_prot_chk #(
        .ID_WIDTH(16), .ADDR_WIDTH(64), .LEN_WIDTH(8), .DATA_WIDTH(512), .FIFO_DEPTH(64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_chk_addr  (cfg_chk_addr),
        .cfg_chk_wr    (cfg_chk_wr),
        .cfg_chk_rd    (cfg_chk_rd),
        .cfg_chk_wdata (cfg_chk_wdata),
        .chk_cfg_ack   (chk_cfg_ack),
        .chk_cfg_rdata (chk_cfg_rdata),
        .rd_error      (rd_error),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic ar(input logic [15:0] id, input logic [7:0] len, input logic [63:0] addr);
        @(negedge clk);
        bus_if.arid = id; bus_if.arlen = len; bus_if.araddr = addr; bus_if.arsize = 3'd6;
        bus_if.arvalid = 1'b1; bus_if.arready = 1'b1;
        @(negedge clk);
        bus_if.arvalid = 1'b0; bus_if.arready = 1'b0;
    endtask

    task automatic rbeat(input logic [15:0] id, input logic last, input logic [1:0] resp);
        @(negedge clk);
        bus_if.rid = id; bus_if.rlast = last; bus_if.rresp = resp; bus_if.rdata = {16{32'hA5A5_0000}};
        bus_if.rvalid = 1'b1; bus_if.rready = 1'b1;
        @(negedge clk);
        bus_if.rvalid = 1'b0; bus_if.rready = 1'b0; bus_if.rlast = 1'b0;
    endtask

    task automatic reg_rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_chk_addr = a; cfg_chk_rd = 1'b1;
        @(negedge clk);
        check("rd_ack", chk_cfg_ack, 1'b1);
        d = chk_cfg_rdata;
        cfg_chk_rd = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] expected);
        logic [31:0] d;
        reg_rd(a, d);
        check(tag, d, expected);
    endtask

    task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_chk_addr = a; cfg_chk_wdata = d; cfg_chk_wr = 1'b1;
        @(negedge clk);
        check("wr_ack", chk_cfg_ack, 1'b1);
        cfg_chk_wr = 1'b0;
    endtask

    initial begin
        bus_if.arid = '0; bus_if.araddr = '0; bus_if.arlen = '0; bus_if.arsize = '0;
        bus_if.arvalid = 1'b0; bus_if.arready = 1'b0;
        bus_if.rid = '0; bus_if.rdata = '0; bus_if.rresp = '0; bus_if.rlast = 1'b0;
        bus_if.rvalid = 1'b0; bus_if.rready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_ack", chk_cfg_ack, 1'b0);
        check("reset_rdata", chk_cfg_rdata, 32'h0);
        check("reset_rd_error", rd_error, 1'b0);
        rd_chk("reset_status", REG_STATUS, 32'h0);
        @(negedge clk);
        check("ack_one_cycle", chk_cfg_ack, 1'b0);
        rd_chk("reset_outstanding", REG_OUTSTANDING, 32'h0);
        rd_chk("unmapped_reads_zero", 12'h018, 32'h0);

        // Good burst: len 3, four beats, RLAST on the fourth
        ar(16'd3, 8'd3, 64'h1000);
        rd_chk("good_outstanding_1", REG_OUTSTANDING, 32'd1);
        rbeat(16'd3, 1'b0, 2'b00);
        rbeat(16'd3, 1'b0, 2'b00);
        rbeat(16'd3, 1'b0, 2'b00);
        rbeat(16'd3, 1'b1, 2'b00);
        rd_chk("good_status", REG_STATUS, 32'h0);
        rd_chk("good_outstanding_0", REG_OUTSTANDING, 32'd0);
        check("good_rd_error", rd_error, 1'b0);

        // RLAST early on beat 1 of a len-3 burst
        ar(16'd5, 8'd3, 64'h2000);
        rbeat(16'd5, 1'b0, 2'b00);
        rbeat(16'd5, 1'b1, 2'b00);
        check("early_rd_error_not_yet", rd_error, 1'b0);
        @(negedge clk);
        check("early_rd_error_next", rd_error, 1'b1);
        rd_chk("early_status", REG_STATUS, 32'h1);
        rd_chk("early_err_addr_lo", REG_ERR_ADDR_LO, 32'h2000);
        rd_chk("early_err_addr_hi", REG_ERR_ADDR_HI, 32'h0);
        rd_chk("early_err_id", REG_ERR_ID, 32'd5);
        rd_chk("early_outstanding", REG_OUTSTANDING, 32'd0);
        reg_wr(REG_STATUS, 32'h1);
        rd_chk("early_cleared", REG_STATUS, 32'h0);

        // len 1, two beats without RLAST, then a stray RLAST beat (gated)
        ar(16'd2, 8'd1, 64'h3000);
        rbeat(16'd2, 1'b0, 2'b00);
        rbeat(16'd2, 1'b0, 2'b00);
        rd_chk("incomplete_status", REG_STATUS, 32'h2);
        rbeat(16'd2, 1'b1, 2'b00);
        rd_chk("incomplete_status_sticky", REG_STATUS, 32'h2);
        rd_chk("incomplete_err_addr_lo", REG_ERR_ADDR_LO, 32'h3000);
        rd_chk("incomplete_err_id", REG_ERR_ID, 32'd2);
        reg_wr(REG_STATUS, 32'h2);

        // Beat with nothing outstanding
        rbeat(16'd9, 1'b1, 2'b00);
        rd_chk("unexp_status", REG_STATUS, 32'h8);
        rd_chk("unexp_err_id", REG_ERR_ID, 32'd0);
        rd_chk("unexp_err_addr_lo", REG_ERR_ADDR_LO, 32'h0);
        check("unexp_rd_error", rd_error, 1'b1);
        reg_wr(REG_STATUS, 32'h8);
        rd_chk("unexp_cleared", REG_STATUS, 32'h0);
        check("unexp_rd_error_drops", rd_error, 1'b0);

        // ID mismatch together with early RLAST: ID mismatch has priority
        ar(16'd4, 8'd2, 64'h4000);
        rbeat(16'd9, 1'b1, 2'b00);
        rd_chk("idmis_status", REG_STATUS, 32'h4);
        rd_chk("idmis_err_addr_lo", REG_ERR_ADDR_LO, 32'h4000);
        rd_chk("idmis_err_id", REG_ERR_ID, 32'd4);
        rd_chk("idmis_outstanding", REG_OUTSTANDING, 32'd0);
        reg_wr(REG_STATUS, 32'h4);

        // Error set and W1C of the same bit in one cycle: set wins
        @(negedge clk);
        bus_if.rid = 16'd1; bus_if.rlast = 1'b1; bus_if.rresp = 2'b00;
        bus_if.rvalid = 1'b1; bus_if.rready = 1'b1;
        cfg_chk_addr = REG_STATUS; cfg_chk_wdata = 32'h8; cfg_chk_wr = 1'b1;
        @(negedge clk);
        bus_if.rvalid = 1'b0; bus_if.rready = 1'b0; bus_if.rlast = 1'b0;
        cfg_chk_wr = 1'b0;
        rd_chk("set_beats_w1c", REG_STATUS, 32'h8);
        reg_wr(REG_STATUS, 32'h8);
        rd_chk("set_beats_w1c_cleared", REG_STATUS, 32'h0);

        // 65 back-to-back ARs into a 64-deep tracker
        @(negedge clk);
        bus_if.arid = 16'd7; bus_if.arlen = 8'd0; bus_if.arvalid = 1'b1; bus_if.arready = 1'b1;
        for (int i = 0; i < 65; i++) begin
            bus_if.araddr = 64'(i) << 6;
            @(negedge clk);
        end
        bus_if.arvalid = 1'b0; bus_if.arready = 1'b0;
        rd_chk("ovf_status", REG_STATUS, 32'h10);
        rd_chk("ovf_outstanding", REG_OUTSTANDING, 32'd64);
        check("ovf_rd_error", rd_error, 1'b1);
        reg_wr(REG_STATUS, 32'h10);

        // Push and pop together while full: no overflow
        @(negedge clk);
        bus_if.arid = 16'd7; bus_if.arlen = 8'd0; bus_if.araddr = 64'hF000;
        bus_if.arvalid = 1'b1; bus_if.arready = 1'b1;
        bus_if.rid = 16'd7; bus_if.rlast = 1'b1; bus_if.rresp = 2'b00;
        bus_if.rvalid = 1'b1; bus_if.rready = 1'b1;
        @(negedge clk);
        bus_if.arvalid = 1'b0; bus_if.arready = 1'b0;
        bus_if.rvalid = 1'b0; bus_if.rready = 1'b0; bus_if.rlast = 1'b0;
        rd_chk("full_pushpop_status", REG_STATUS, 32'h0);
        rd_chk("full_pushpop_outstanding", REG_OUTSTANDING, 32'd64);

        // Ten SLVERR beats, each completing a len-0 burst
        for (int i = 0; i < 10; i++) rbeat(16'd7, 1'b1, 2'b10);
        rd_chk("slverr_cnt_10", REG_SLVERR_CNT, 32'd10);
        rd_chk("slverr_outstanding", REG_OUTSTANDING, 32'd54);
        rd_chk("slverr_status", REG_STATUS, 32'h0);
        reg_wr(REG_SLVERR_CNT, 32'h0);
        rd_chk("slverr_cleared", REG_SLVERR_CNT, 32'd0);

        // Mid-burst error, then reset: everything clears
        rbeat(16'd7, 1'b0, 2'b10);
        rd_chk("pre_reset_status", REG_STATUS, 32'h2);
        rd_chk("pre_reset_err_addr", REG_ERR_ADDR_LO, 32'h2C0);
        rd_chk("pre_reset_slverr", REG_SLVERR_CNT, 32'd1);
        rd_chk("pre_reset_outstanding", REG_OUTSTANDING, 32'd53);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("in_reset_rd_error", rd_error, 1'b0);
        rst_n = 1'b1;
        rd_chk("post_reset_status", REG_STATUS, 32'h0);
        rd_chk("post_reset_err_addr", REG_ERR_ADDR_LO, 32'h0);
        rd_chk("post_reset_err_id", REG_ERR_ID, 32'h0);
        rd_chk("post_reset_outstanding", REG_OUTSTANDING, 32'd0);
        rd_chk("post_reset_slverr", REG_SLVERR_CNT, 32'd0);
        rbeat(16'd7, 1'b0, 2'b00);
        rbeat(16'd7, 1'b1, 2'b00);
        rd_chk("aborted_burst_status", REG_STATUS, 32'h8);
        rd_chk("aborted_burst_err_id", REG_ERR_ID, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
